// File: rtl/mem_access_unit_pkg.sv
// Shared encodings and helpers for the MEM-stage access engine.
package mem_access_unit_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  function automatic logic f3_legal(logic store, logic [2:0] f3);
    if (store) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic misaligned(logic [2:0] f3, logic [1:0] lo);
    case (f3)
      F3_H, F3_HU: return lo[0];
      F3_W:        return lo != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_formatter.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
module mem_access_unit_load_formatter
  import mem_access_unit_pkg::*;
(
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        addr_lo,
  input  logic [2:0]        funct3,
  output logic [DATA_W-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    unique case (addr_lo)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    result = {{16{half_sel[15]}}, half_sel};
      F3_BU:   result = {24'h000000, byte_sel};
      F3_HU:   result = {16'h0000, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access engine: request/response bus transaction with
// load/store formatting, pipeline stall and timeout abort.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_rd_in,
  input  logic              mem_wr_in,
  input  logic [2:0]        funct3_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  output logic              stall,
  output logic [DATA_W-1:0] load_data,
  output logic              done,
  output logic              fault,
  output logic              req_valid,
  output logic              req_we,
  output logic [ADDR_W-1:0] req_addr,
  output logic [DATA_W-1:0] req_wdata,
  output logic [BE_W-1:0]   req_be,
  input  logic              req_ready,
  input  logic              resp_valid,
  input  logic [DATA_W-1:0] resp_rdata
);

  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYC - 1);

  state_e            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        f3_q, f3_d;
  logic              we_q, we_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              tout_q, tout_d;

  logic              access, access_ok, timeout_hit;
  logic [BE_W-1:0]   be_fmt;
  logic [DATA_W-1:0] wdata_fmt;
  logic [DATA_W-1:0] load_fmt;

  mem_access_unit_load_formatter u_load_formatter (
    .rdata   (resp_rdata),
    .addr_lo (addr_q[1:0]),
    .funct3  (f3_q),
    .result  (load_fmt)
  );

  assign access      = mem_rd_in | mem_wr_in;
  assign access_ok   = (mem_rd_in ^ mem_wr_in) && f3_legal(mem_wr_in, funct3_in) &&
                       !misaligned(funct3_in, addr_in[1:0]);
  assign timeout_hit = (cnt_q == TimeoutLast);

  // Byte enables follow the access size for loads too, so the bus sees the read footprint.
  always_comb begin
    case (funct3_in[1:0])
      2'b00: begin
        be_fmt    = 4'b0001 << addr_in[1:0];
        wdata_fmt = {4{wdata_in[7:0]}};
      end
      2'b01: begin
        be_fmt    = 4'b0011 << addr_in[1:0];
        wdata_fmt = {2{wdata_in[15:0]}};
      end
      default: begin
        be_fmt    = 4'b1111;
        wdata_fmt = wdata_in;
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    f3_d      = f3_q;
    we_d      = we_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    data_d    = data_q;
    tout_d    = tout_q;
    stall     = 1'b0;
    done      = 1'b0;
    fault     = 1'b0;
    req_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (access) begin
          if (access_ok) begin
            stall   = 1'b1;
            addr_d  = addr_in;
            f3_d    = funct3_in;
            we_d    = mem_wr_in;
            be_d    = be_fmt;
            wdata_d = wdata_fmt;
            cnt_d   = '0;
            data_d  = '0;
            tout_d  = 1'b0;
            state_d = StReq;
          end else begin
            fault = 1'b1;
            done  = 1'b1;
          end
        end
      end
      StReq: begin
        req_valid = 1'b1;
        stall     = 1'b1;
        cnt_d     = cnt_q + 16'd1;
        if (req_ready) begin
          state_d = we_q ? StDone : StWait;
        end else if (timeout_hit) begin
          tout_d  = 1'b1;
          state_d = StDone;
        end
      end
      StWait: begin
        stall = 1'b1;
        cnt_d = cnt_q + 16'd1;
        if (resp_valid) begin
          data_d  = load_fmt;
          state_d = StDone;
        end else if (timeout_hit) begin
          tout_d  = 1'b1;
          data_d  = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        done    = 1'b1;
        fault   = tout_q;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      tout_q  <= tout_d;
    end
  end

  assign load_data = (state_q == StDone) ? data_q : '0;
  assign req_we    = we_q;
  assign req_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign req_wdata = wdata_q;
  assign req_be    = be_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed accesses, bus model, queue-based monitors.
module tb_mem_access_unit;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  typedef struct packed {
    logic        fault;
    logic [31:0] data;
  } done_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_rd_in, mem_wr_in;
  logic [2:0]  funct3_in;
  logic [31:0] addr_in, wdata_in;
  logic        stall, done, fault;
  logic [31:0] load_data;
  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        req_ready, resp_valid;
  logic [31:0] resp_rdata;

  int    checks = 0;
  int    errors = 0;
  int    rv_cycles = 0;
  req_t  req_q[$];
  done_t done_q[$];

  bit          ready_en = 1'b1;
  int          resp_wait = 0;
  logic [31:0] resp_word = 32'h0;

  mem_access_unit #(
    .TIMEOUT_CYC (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_rd_in  (mem_rd_in),
    .mem_wr_in  (mem_wr_in),
    .funct3_in  (funct3_in),
    .addr_in    (addr_in),
    .wdata_in   (wdata_in),
    .stall      (stall),
    .load_data  (load_data),
    .done       (done),
    .fault      (fault),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_be     (req_be),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_req(input logic we, input logic [31:0] a, wd, input logic [3:0] be);
    req_t r;
    r.we = we; r.addr = a; r.wdata = wd; r.be = be;
    req_q.push_back(r);
  endtask

  task automatic push_done(input logic f, input logic [31:0] d);
    done_t e;
    e.fault = f; e.data = d;
    done_q.push_back(e);
  endtask

  // Holds one instruction on the EX/MEM inputs until it completes; counts stall cycles.
  task automatic do_access(input logic rd, wr, input logic [2:0] f3, input logic [31:0] a, wd,
                           input int exp_stall, input string name);
    int  n = 0;
    bit  seen = 1'b0;
    mem_rd_in = rd; mem_wr_in = wr; funct3_in = f3; addr_in = a; wdata_in = wd;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        chk({name, "_stall_in_done"}, {31'b0, stall}, 32'd0);
      end else if (stall) begin
        n++;
      end
    end
    chk({name, "_completed"}, {31'b0, seen}, 32'd1);
    chk({name, "_stall_cycles"}, n, exp_stall);
    @(posedge clk); #1;
    mem_rd_in = 1'b0; mem_wr_in = 1'b0; funct3_in = 3'b000; addr_in = '0; wdata_in = '0;
  endtask

  // Bus model: ready follows ready_en; a read gets resp_wait empty WAIT cycles, then data.
  initial begin
    bit pend = 1'b0;
    int dly = 0;
    req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = '0;
    forever begin
      @(negedge clk);
      if (req_valid && req_ready && !req_we && !rst) begin
        pend = 1'b1;
        dly  = resp_wait;
      end
      @(posedge clk); #1;
      resp_valid = 1'b0; resp_rdata = '0;
      if (pend) begin
        if (dly == 0) begin
          resp_valid = 1'b1; resp_rdata = resp_word; pend = 1'b0;
        end else begin
          dly--;
        end
      end
      req_ready = ready_en;
    end
  end

  // Completion monitor.
  initial begin
    done_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        if (done_q.size() == 0) begin
          chk("unexpected_done", {31'b0, done}, 32'd0);
        end else begin
          e = done_q.pop_front();
          chk("done_fault", {31'b0, fault}, {31'b0, e.fault});
          chk("load_data", load_data, e.data);
        end
      end
    end
  end

  // Request monitor: pops on the first cycle of a request, checks fields every valid cycle.
  initial begin
    req_t cur = '0;
    bit   prev = 1'b0;
    forever begin
      @(negedge clk);
      if (req_valid) begin
        rv_cycles++;
        if (!prev) begin
          if (req_q.size() == 0) chk("unexpected_req", {31'b0, req_valid}, 32'd0);
          else cur = req_q.pop_front();
        end
        chk("req_we", {31'b0, req_we}, {31'b0, cur.we});
        chk("req_addr", req_addr, cur.addr);
        chk("req_wdata", req_wdata, cur.wdata);
        chk("req_be", {28'b0, req_be}, {28'b0, cur.be});
      end
      prev = req_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    mem_rd_in = 1'b0; mem_wr_in = 1'b0; funct3_in = 3'b000; addr_in = '0; wdata_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    chk("rst_req_valid", {31'b0, req_valid}, 32'd0);
    chk("rst_req_we", {31'b0, req_we}, 32'd0);
    chk("rst_req_addr", req_addr, 32'd0);
    chk("rst_req_wdata", req_wdata, 32'd0);
    chk("rst_req_be", {28'b0, req_be}, 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // SW
    push_req(1'b1, 32'h100, 32'hDEADBEEF, 4'b1111);
    push_done(1'b0, 32'h0);
    do_access(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 2, "sw");

    // LB / LBU with two empty wait cycles
    resp_word = 32'h80FF7F01; resp_wait = 2;
    push_req(1'b0, 32'h200, 32'h0, 4'b1000);
    push_done(1'b0, 32'hFFFFFF80);
    do_access(1'b1, 1'b0, 3'b000, 32'h203, 32'h0, 5, "lb");
    push_req(1'b0, 32'h200, 32'h0, 4'b1000);
    push_done(1'b0, 32'h00000080);
    do_access(1'b1, 1'b0, 3'b100, 32'h203, 32'h0, 5, "lbu");

    // LHU / LH upper half, one wait cycle
    resp_wait = 1;
    push_req(1'b0, 32'h500, 32'h0, 4'b1100);
    push_done(1'b0, 32'h000080FF);
    do_access(1'b1, 1'b0, 3'b101, 32'h502, 32'h0, 4, "lhu");
    push_req(1'b0, 32'h500, 32'h0, 4'b1100);
    push_done(1'b0, 32'hFFFF80FF);
    do_access(1'b1, 1'b0, 3'b001, 32'h502, 32'h0, 4, "lh");

    // SH, SB lane shifts
    push_req(1'b1, 32'h300, 32'hABCDABCD, 4'b1100);
    push_done(1'b0, 32'h0);
    do_access(1'b0, 1'b1, 3'b001, 32'h302, 32'h0000ABCD, 2, "sh");
    push_req(1'b1, 32'h100, 32'hA5A5A5A5, 4'b0010);
    push_done(1'b0, 32'h0);
    do_access(1'b0, 1'b1, 3'b000, 32'h101, 32'h123456A5, 2, "sb");

    // Misaligned and illegal: immediate fault, no request
    push_done(1'b1, 32'h0);
    do_access(1'b1, 1'b0, 3'b001, 32'h301, 32'h0, 0, "lh_misaligned");
    push_done(1'b1, 32'h0);
    do_access(1'b0, 1'b1, 3'b010, 32'h102, 32'h0, 0, "sw_misaligned");
    push_done(1'b1, 32'h0);
    do_access(1'b1, 1'b1, 3'b010, 32'h100, 32'h0, 0, "rd_and_wr");
    push_done(1'b1, 32'h0);
    do_access(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 0, "f3_011");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("nop_stall", {31'b0, stall}, 32'd0);
      chk("nop_done", {31'b0, done}, 32'd0);
      @(posedge clk); #1;
    end

    // Timeout with the bus never ready
    ready_en = 1'b0;
    @(posedge clk); #1;
    rv_cycles = 0;
    push_req(1'b0, 32'h400, 32'h0, 4'b1111);
    push_done(1'b1, 32'h0);
    do_access(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 9, "timeout");
    chk("timeout_req_cycles", rv_cycles, 32'd8);
    ready_en = 1'b1;
    @(posedge clk); #1;

    // Reset during WAIT, response arrives the cycle after
    resp_word = 32'hCAFEF00D; resp_wait = 1;
    push_req(1'b0, 32'h600, 32'h0, 4'b1111);
    mem_rd_in = 1'b1; funct3_in = 3'b010; addr_in = 32'h600;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; mem_rd_in = 1'b0; funct3_in = 3'b000; addr_in = '0;
    @(negedge clk);
    chk("wait_stall", {31'b0, stall}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_stall", {31'b0, stall}, 32'd0);
    chk("post_rst_req_valid", {31'b0, req_valid}, 32'd0);
    chk("post_rst_done", {31'b0, done}, 32'd0);
    repeat (3) @(posedge clk);
    #1;

    // Normal load after the abort
    resp_word = 32'h12345678; resp_wait = 0;
    push_req(1'b0, 32'h40C, 32'h0, 4'b1111);
    push_done(1'b0, 32'h12345678);
    do_access(1'b1, 1'b0, 3'b010, 32'h40C, 32'h0, 3, "lw");

    repeat (3) @(posedge clk);
    chk("req_queue_empty", req_q.size(), 32'd0);
    chk("done_queue_empty", done_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
